credit_datapath: RTL and testbench
==================================

# credit_datapath

Credit accumulator and price comparator for the coffee-machine controller. Consumes the control unit's selector and counter strobes (`sel_en`, `sel_sel`, `Cnt_*`), keeps the inserted-credit register, and returns the three price-compare flags the control FSM branches on in its compare state. Also keeps saturating audit counters for completed sales and refunded coins, for the LCD and service readout.

## Interface
Parameters:
- `PRICE`, 3: price of one cup in RMB; compare threshold.
- `COIN_SMALL`, 1: credit added when `sel_sel`=0.
- `COIN_LARGE`, 5: credit added when `sel_sel`=1.
- `CREDIT_W`, 4: credit register width; maximum credit is 2^CREDIT_W−1.
- `AUDIT_W`, 8: width of the sales and refund counters.

Ports:
- `Clock`  in  1  single system clock; all state updates on the rising edge.
- `Reset_n`  in  1  reset, synchronous, active-low.
- `sel_en`  in  1  coin-value selector enable.
- `sel_sel`  in  1  coin value select: 0 = `COIN_SMALL`, 1 = `COIN_LARGE`.
- `Cnt_clr`  in  1  active-low credit clear.
- `Cnt_en`  in  1  counter enable.
- `Cnt_ld`  in  1  add selected coin value.
- `Cnt_ud`  in  1  count down by 1 (one coin refunded).
- `Less_3`  out  1  credit < `PRICE`.
- `Eql_3`  out  1  credit == `PRICE`.
- `Grt_3`  out  1  credit > `PRICE`.
- `Credit`  out  `CREDIT_W`  current credit.
- `Credit_ovf`  out  1  sticky; set when an add saturated.
- `Sales_cnt`  out  `AUDIT_W`  completed sales, saturating.
- `Change_cnt`  out  `AUDIT_W`  coins refunded, saturating.

## Operation
Register update priority, evaluated each rising edge, highest first:
1. `Reset_n`=0: Credit, `Credit_ovf`, `Sales_cnt` and `Change_cnt` all go to 0.
2. `Cnt_clr`=0: Credit goes to 0. If Credit == `PRICE` before the clear, `Sales_cnt` increments. `Credit_ovf` is cleared. The clear wins over any `Cnt_en` in the same cycle.
3. `Cnt_en`=1, `Cnt_ld`=1 and `sel_en`=1:
   - Credit becomes Credit + value, where value is `COIN_LARGE` if `sel_sel`=1, else `COIN_SMALL`.
   - The sum is computed at `CREDIT_W`+1 bits.
   - If the sum exceeds 2^CREDIT_W−1, Credit takes that maximum and `Credit_ovf` is set.
   - This add wins over `Cnt_ud` in the same cycle.
4. `Cnt_en`=1 and `Cnt_ud`=1:
   - If Credit > 0: Credit decrements by 1 and `Change_cnt` increments.
   - If Credit = 0: Credit holds and `Change_cnt` holds (no underflow).
5. Otherwise all registers hold. This explicitly covers:
   - `Cnt_ld`=1 with `Cnt_en`=0;
   - `Cnt_en`=1, `Cnt_ld`=1 with `sel_en`=0;
   - `Cnt_en`=1 with both `Cnt_ld` and `Cnt_ud` low.

Other rules:
- Flags are decoded combinationally from the Credit register. Exactly one of `Less_3`/`Eql_3`/`Grt_3` is high at all times, including during reset.
- Audit counters saturate at 2^AUDIT_W−1; they never wrap.

## Timing
- Zero-cycle flag path: a strobe asserted in cycle N updates Credit at the end of N, and the flags reflect the new value throughout cycle N+1. This matches the control FSM, which goes add state → compare state.
- Reset values: Credit=0, `Less_3`=1, `Eql_3`=0, `Grt_3`=0, `Credit_ovf`=0, `Sales_cnt`=0, `Change_cnt`=0.
- Reset asserted mid-operation discards credit and audit counts at the next edge. There are no async paths.
- Inputs are sampled only on `Clock`. Strobes are level-sensitive, and each cycle held applies the operation again (e.g. `Cnt_ud` held 2 cycles refunds 2 coins).

## Structure
- Shared package `coffee_pkg` holds:
  - `PRICE`, `COIN_SMALL`, `COIN_LARGE` defaults, so the control unit and the datapath agree;
  - the credit width constant.
- One sub-module, `sat_counter` (parameter `W`; inputs `inc` and `clr`; saturating output). It is instantiated twice, for `Sales_cnt` and `Change_cnt`.
- The credit register, adder and comparator stay inline in `credit_datapath`.

## Test plan
- Three 1-RMB coins: after reset, pulse `Cnt_en`+`Cnt_ld`+`sel_en`, `sel_sel`=0, for 1 cycle, three times → Credit goes 1, 2, 3. The flags read `Less_3`, `Less_3`, `Eql_3` in the cycle after each pulse.
- One 5-RMB coin, then refund: one add with `sel_sel`=1 → Credit=5, `Grt_3`=1. Then `Cnt_en`+`Cnt_ud` for 2 cycles → Credit=3, `Eql_3`=1, `Change_cnt`=2.
- Sale accounting:
  - At Credit=3, `Cnt_clr`=0 for 1 cycle → Credit=0, `Sales_cnt`=1.
  - Repeat the clear at Credit=2 → `Sales_cnt` stays 1.
- Saturation and underflow:
  - Four 5-RMB adds → Credit=15, `Credit_ovf`=1.
  - Starting from Credit=0, `Cnt_ud` with `Cnt_en` → Credit=0, `Change_cnt` unchanged.
- Simultaneous strobes:
  - `Cnt_ld`+`Cnt_ud`+`Cnt_en`+`sel_en` at Credit=2, `sel_sel`=0 → Credit=3 (the add wins).
  - `Cnt_clr`=0 with `Cnt_en`=1 → Credit=0.
- Reset mid-operation: at Credit=4, `Sales_cnt`=2, drive `Reset_n`=0 for 1 cycle together with an add strobe → all registers are 0 and `Less_3`=1 after the edge.

Source files
------------

// File: rtl/coffee_pkg.sv
// rtl/coffee_pkg.sv - shared price, coin and width defaults for the coffee-machine controller
package coffee_pkg;

    localparam int DEF_PRICE      = 3;
    localparam int DEF_COIN_SMALL = 1;
    localparam int DEF_COIN_LARGE = 5;
    localparam int DEF_CREDIT_W   = 4;
    localparam int DEF_AUDIT_W    = 8;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones instead of wrapping
module sat_counter
    import coffee_pkg::*;
#(
    parameter int W = DEF_AUDIT_W
) (
    input  logic         Clock,
    input  logic         Reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/credit_datapath.sv
// rtl/credit_datapath.sv - credit register, coin adder, price compare and audit counters
module credit_datapath
    import coffee_pkg::*;
#(
    parameter int PRICE      = DEF_PRICE,
    parameter int COIN_SMALL = DEF_COIN_SMALL,
    parameter int COIN_LARGE = DEF_COIN_LARGE,
    parameter int CREDIT_W   = DEF_CREDIT_W,
    parameter int AUDIT_W    = DEF_AUDIT_W
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                sel_en,
    input  logic                sel_sel,
    input  logic                Cnt_clr,
    input  logic                Cnt_en,
    input  logic                Cnt_ld,
    input  logic                Cnt_ud,
    output logic                Less_3,
    output logic                Eql_3,
    output logic                Grt_3,
    output logic [CREDIT_W-1:0] Credit,
    output logic                Credit_ovf,
    output logic [AUDIT_W-1:0]  Sales_cnt,
    output logic [AUDIT_W-1:0]  Change_cnt
);

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;
    localparam logic [CREDIT_W-1:0] PRICE_V    = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   SMALL_V    = (CREDIT_W + 1)'(COIN_SMALL);
    localparam logic [CREDIT_W:0]   LARGE_V    = (CREDIT_W + 1)'(COIN_LARGE);

    logic [CREDIT_W-1:0] credit_q;
    logic                ovf_q;
    logic [CREDIT_W:0]   sum;
    logic                do_clr;
    logic                do_add;
    logic                do_refund;

    // Priority: clear over add over refund; refund never takes credit below zero.
    assign do_clr    = ~Cnt_clr;
    assign do_add    = ~do_clr & Cnt_en & Cnt_ld & sel_en;
    assign do_refund = ~do_clr & ~do_add & Cnt_en & Cnt_ud & (credit_q != '0);
    assign sum       = {1'b0, credit_q} + (sel_sel ? LARGE_V : SMALL_V);

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            credit_q <= '0;
            ovf_q    <= 1'b0;
        end else if (do_clr) begin
            credit_q <= '0;
            ovf_q    <= 1'b0;
        end else if (do_add) begin
            if (sum[CREDIT_W]) begin
                credit_q <= CREDIT_MAX;
                ovf_q    <= 1'b1;
            end else begin
                credit_q <= sum[CREDIT_W-1:0];
            end
        end else if (do_refund) begin
            credit_q <= credit_q - 1'b1;
        end
    end

    assign Credit     = credit_q;
    assign Credit_ovf = ovf_q;
    assign Less_3     = (credit_q <  PRICE_V);
    assign Eql_3      = (credit_q == PRICE_V);
    assign Grt_3      = (credit_q >  PRICE_V);

    // A clear taken exactly at the price is a completed sale.
    sat_counter #(.W(AUDIT_W)) u_sales (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .clr     (1'b0),
        .inc     (do_clr & (credit_q == PRICE_V)),
        .count   (Sales_cnt)
    );

    sat_counter #(.W(AUDIT_W)) u_change (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .clr     (1'b0),
        .inc     (do_refund),
        .count   (Change_cnt)
    );

endmodule

// File: tb/tb_credit_datapath.sv
// tb/tb_credit_datapath.sv - directed-vector scoreboard bench for credit_datapath
module tb_credit_datapath;

    logic       Clock = 1'b0;
    logic       Reset_n, sel_en, sel_sel, Cnt_clr, Cnt_en, Cnt_ld, Cnt_ud;
    logic       Less_3, Eql_3, Grt_3, Credit_ovf;
    logic [3:0] Credit;
    logic [7:0] Sales_cnt, Change_cnt;

    typedef struct {
        int       idx;
        int       credit;
        logic [2:0] flags;
        logic     ovf;
        int       sales;
        int       change;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    localparam logic [2:0] LT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] GT = 3'b001;

    credit_datapath dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .sel_en     (sel_en),
        .sel_sel    (sel_sel),
        .Cnt_clr    (Cnt_clr),
        .Cnt_en     (Cnt_en),
        .Cnt_ld     (Cnt_ld),
        .Cnt_ud     (Cnt_ud),
        .Less_3     (Less_3),
        .Eql_3      (Eql_3),
        .Grt_3      (Grt_3),
        .Credit     (Credit),
        .Credit_ovf (Credit_ovf),
        .Sales_cnt  (Sales_cnt),
        .Change_cnt (Change_cnt)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input int idx, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL step %0d %s: got %0d expected %0d", idx, name, act, req);
        end
    endtask

    always @(negedge Clock) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("credit", e.idx, int'(Credit), e.credit);
            check("flags", e.idx, int'({Less_3, Eql_3, Grt_3}), int'(e.flags));
            check("ovf", e.idx, int'(Credit_ovf), int'(e.ovf));
            check("sales", e.idx, int'(Sales_cnt), e.sales);
            check("change", e.idx, int'(Change_cnt), e.change);
        end
    end

    // Inputs: rst_n sel_en sel_sel clr_n en ld ud; expectations hold after the edge.
    task automatic step(input logic rn, input logic se, input logic ss, input logic cn,
                        input logic en, input logic ld, input logic ud,
                        input int e_cr, input logic [2:0] e_fl, input logic e_ovf,
                        input int e_sales, input int e_change);
        exp_t e;
        Reset_n = rn; sel_en = se; sel_sel = ss; Cnt_clr = cn;
        Cnt_en = en; Cnt_ld = ld; Cnt_ud = ud;
        @(posedge Clock);
        e.idx = step_no; e.credit = e_cr; e.flags = e_fl; e.ovf = e_ovf;
        e.sales = e_sales; e.change = e_change;
        exp_q.push_back(e);
        step_no++;
        #1;
    endtask

    function automatic logic [2:0] flags_of(input int c);
        return (c < 3) ? LT : ((c == 3) ? EQ : GT);
    endfunction

    initial begin
        int chg;
        int cr;
        // reset
        step(0, 0, 0, 1, 0, 0, 0,  0, LT, 0, 0, 0);
        // three small coins
        step(1, 1, 0, 1, 1, 1, 0,  1, LT, 0, 0, 0);
        step(1, 1, 0, 1, 1, 1, 0,  2, LT, 0, 0, 0);
        step(1, 1, 0, 1, 1, 1, 0,  3, EQ, 0, 0, 0);
        // sale at price
        step(1, 0, 0, 0, 0, 0, 0,  0, LT, 0, 1, 0);
        // large coin, then two refunds
        step(1, 1, 1, 1, 1, 1, 0,  5, GT, 0, 1, 0);
        step(1, 0, 0, 1, 1, 0, 1,  4, GT, 0, 1, 1);
        step(1, 0, 0, 1, 1, 0, 1,  3, EQ, 0, 1, 2);
        // hold cases: ld without en, en+ld without sel_en, en alone
        step(1, 1, 1, 1, 0, 1, 0,  3, EQ, 0, 1, 2);
        step(1, 0, 1, 1, 1, 1, 0,  3, EQ, 0, 1, 2);
        step(1, 0, 0, 1, 1, 0, 0,  3, EQ, 0, 1, 2);
        step(1, 0, 0, 0, 0, 0, 0,  0, LT, 0, 2, 2);
        // clear at credit 2 is not a sale
        step(1, 1, 0, 1, 1, 1, 0,  1, LT, 0, 2, 2);
        step(1, 1, 0, 1, 1, 1, 0,  2, LT, 0, 2, 2);
        step(1, 0, 0, 0, 0, 0, 0,  0, LT, 0, 2, 2);
        // credit saturation
        step(1, 1, 1, 1, 1, 1, 0,  5, GT, 0, 2, 2);
        step(1, 1, 1, 1, 1, 1, 0, 10, GT, 0, 2, 2);
        step(1, 1, 1, 1, 1, 1, 0, 15, GT, 0, 2, 2);
        step(1, 1, 1, 1, 1, 1, 0, 15, GT, 1, 2, 2);
        step(1, 0, 0, 1, 1, 0, 1, 14, GT, 1, 2, 3);
        // clear beats a same-cycle add and drops the overflow flag
        step(1, 1, 1, 0, 1, 1, 0,  0, LT, 0, 2, 3);
        // no underflow
        step(1, 0, 0, 1, 1, 0, 1,  0, LT, 0, 2, 3);
        // add beats refund
        step(1, 1, 0, 1, 1, 1, 0,  1, LT, 0, 2, 3);
        step(1, 1, 0, 1, 1, 1, 0,  2, LT, 0, 2, 3);
        step(1, 1, 0, 1, 1, 1, 1,  3, EQ, 0, 2, 3);
        step(1, 1, 0, 1, 1, 1, 0,  4, GT, 0, 2, 3);
        // reset with an add strobe present
        step(0, 1, 1, 1, 1, 1, 0,  0, LT, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1, 0,  5, GT, 0, 0, 0);
        // drive Change_cnt to 255 and confirm it sticks
        chg = 0;
        for (int i = 4; i >= 0; i--) begin
            chg++;
            step(1, 0, 0, 1, 1, 0, 1, i, flags_of(i), 0, 0, chg);
        end
        for (int r = 0; r < 17; r++) begin
            int n;
            n = (r == 16) ? 2 : 3;
            cr = 0;
            for (int k = 0; k < n; k++) begin
                cr = cr + 5;
                step(1, 1, 1, 1, 1, 1, 0, cr, flags_of(cr), 0, 0, chg);
            end
            while (cr > 0) begin
                cr--;
                chg++;
                step(1, 0, 0, 1, 1, 0, 1, cr, flags_of(cr), 0, 0, chg);
            end
        end
        step(1, 1, 1, 1, 1, 1, 0,  5, GT, 0, 0, 255);
        step(1, 0, 0, 1, 1, 0, 1,  4, GT, 0, 0, 255);
        step(1, 0, 0, 1, 0, 0, 0,  4, GT, 0, 0, 255);
        for (int w = 0; w < 4 && exp_q.size() != 0; w++) @(negedge Clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
